// File: rtl/bit_frame_deser_if.sv
// Output-side bus of bit_frame_deser: one deserialized word plus its
// frame qualifiers, moved with a valid/ready handshake.
// BIT_FRAME_PARITY_EN adds the parity_err qualifier to the bus.
interface bit_frame_deser_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              frame_first;
  logic              frame_last;
`ifdef BIT_FRAME_PARITY_EN
  logic              parity_err;

  modport master (output dout, dout_valid, frame_first, frame_last, parity_err,
                  input  dout_ready);
  modport slave  (input  dout, dout_valid, frame_first, frame_last, parity_err,
                  output dout_ready);
`else
  modport master (output dout, dout_valid, frame_first, frame_last,
                  input  dout_ready);
  modport slave  (input  dout, dout_valid, frame_first, frame_last,
                  output dout_ready);
`endif
endinterface

// File: rtl/bit_frame_deser.sv
// bit_frame_deser: after each lock pulse from the sync detector, collects
// FRAME_WORDS words of DATA_W bits (MSB first) from the serial stream and
// presents them one at a time in a valid/ready output register. A word
// that completes while the register still holds an unconsumed word is
// dropped and flagged in the sticky overrun bit.
// Optional feature macro: BIT_FRAME_PARITY_EN (one even-parity bit follows
// each word's LSB; parity_err travels with the word on the bus).
module bit_frame_deser #(
  parameter int DATA_W      = 8,
  parameter int FRAME_WORDS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  input  logic i_lock,
  input  logic i_ovr_clr,
  output logic o_overrun,
  bit_frame_deser_if.master bus
);

`ifdef BIT_FRAME_PARITY_EN
  localparam int WORD_BITS = DATA_W + 1;
`else
  localparam int WORD_BITS = DATA_W;
`endif
  localparam int BCW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_BITS - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);

  typedef enum logic {HUNT, SHIFT} state_t;

  state_t            r_state, w_state_next;
  logic [BCW-1:0]    r_bit_cnt, w_bit_cnt_next;
  logic [WCW-1:0]    r_word_cnt, w_word_cnt_next;
  logic [DATA_W-1:0] r_shreg;
  logic              w_shift_en;
  logic              w_word_done;
  logic              w_load;
  logic              w_drop;
  logic [DATA_W-1:0] w_word;
  logic              w_perr;

  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_first;
  logic              r_last;
  logic              r_overrun;
  logic              r_perr;

  // Next-state and counter logic; lock only matters while hunting
  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_word_cnt_next = r_word_cnt;
    w_shift_en      = 1'b0;
    w_word_done     = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (i_lock) begin
          w_state_next    = SHIFT;
          w_shift_en      = 1'b1;
          w_bit_cnt_next  = BCW'(1);
          w_word_cnt_next = '0;
        end
      end
      SHIFT: begin
        w_shift_en = 1'b1;
        if (r_bit_cnt == BIT_LAST) begin
          w_word_done    = 1'b1;
          w_bit_cnt_next = '0;
          if (r_word_cnt == WORD_LAST) begin
            w_state_next    = HUNT;
            w_word_cnt_next = '0;
          end else begin
            w_word_cnt_next = r_word_cnt + WCW'(1);
          end
        end else begin
          w_bit_cnt_next = r_bit_cnt + BCW'(1);
        end
      end
      default: w_state_next = HUNT;
    endcase
  end

`ifdef BIT_FRAME_PARITY_EN
  // The shift register already holds the full payload when the parity bit arrives
  always_comb begin
    w_word = r_shreg;
    w_perr = ^{r_shreg, i_din};
  end
`else
  // The word is completed by the bit arriving at this edge
  always_comb begin
    w_word = {r_shreg[DATA_W-2:0], i_din};
    w_perr = 1'b0;
  end
`endif

  // Output register accepts a new word if it is empty or being emptied now
  always_comb begin
    w_load = w_word_done && (!r_valid || bus.dout_ready);
    w_drop = w_word_done && r_valid && !bus.dout_ready;
  end

  // FSM state and bit/word counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HUNT;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_word_cnt <= w_word_cnt_next;
    end
  end

  // Serial-to-parallel shift register, MSB arrives first
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (w_shift_en) begin
      r_shreg <= {r_shreg[DATA_W-2:0], i_din};
    end
  end

  // Output word register with valid/ready handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_perr  <= 1'b0;
    end else if (w_load) begin
      r_dout  <= w_word;
      r_valid <= 1'b1;
      r_first <= (r_word_cnt == '0);
      r_last  <= (r_word_cnt == WORD_LAST);
      r_perr  <= w_perr;
    end else if (r_valid && bus.dout_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overrun flag; a new drop wins over a clear at the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (i_ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign bus.dout        = r_dout;
  assign bus.dout_valid  = r_valid;
  assign bus.frame_first = r_first;
  assign bus.frame_last  = r_last;
  assign o_overrun       = r_overrun;
`ifdef BIT_FRAME_PARITY_EN
  assign bus.parity_err  = r_perr;
`endif

endmodule

// File: tb/tb_bit_frame_deser.sv
// Testbench for bit_frame_deser. A behavioural model collects bits into
// integers per frame and tracks the output register; every cycle the DUT
// outputs are compared against it. Directed frames cover reset, plain
// delivery, backpressure, a same-edge accept, lock noise inside payload
// and a mid-frame reset, followed by randomized frames.
module tb_bit_frame_deser;

  localparam int DATA_W      = 8;
  localparam int FRAME_WORDS = 4;
`ifdef BIT_FRAME_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int WB = DATA_W + PAR;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic lock = 1'b0;
  logic ovrClr = 1'b0;
  logic overrun;

  bit_frame_deser_if #(.DATA_W(DATA_W)) bus();

  bit_frame_deser #(.DATA_W(DATA_W), .FRAME_WORDS(FRAME_WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_din     (din),
    .i_lock    (lock),
    .i_ovr_clr (ovrClr),
    .o_overrun (overrun),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit                mInFrame = 0;
  int                mBits    = 0;
  int                mWord    = 0;
  longint            mAcc     = 0;
  logic [DATA_W-1:0] mDout    = '0;
  bit                mValid   = 0;
  bit                mFirst   = 0;
  bit                mLast    = 0;
  bit                mOvr     = 0;
  bit                mPerr    = 0;

  logic [DATA_W-1:0] delivered[$];
  logic [DATA_W-1:0] expWords[$];

  int lockNoise = 0;
  int readyMode = 0;
  int readyAt   = -1;
  int clrPct    = 0;
  int parFlip   = 0;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Model of one clock edge, driven by the frame/word rules
  task automatic modelStep(input logic d, input logic lk, input logic rd, input logic cl, input logic rs);
    bit done;
    bit setOvr;
    int wIdx;
    longint acc;
    done   = 0;
    setOvr = 0;
    wIdx   = 0;
    acc    = 0;
    if (rs) begin
      mInFrame = 0; mBits = 0; mWord = 0; mAcc = 0;
      mDout = '0; mValid = 0; mFirst = 0; mLast = 0; mOvr = 0; mPerr = 0;
      return;
    end
    if (!mInFrame) begin
      if (lk) begin
        mInFrame = 1;
        mAcc     = longint'(d);
        mBits    = 1;
        mWord    = 0;
      end
    end else begin
      mAcc = mAcc * 2 + longint'(d);
      mBits++;
      if (mBits == WB) begin
        done  = 1;
        wIdx  = mWord;
        acc   = mAcc;
        mBits = 0;
        mAcc  = 0;
        if (mWord == FRAME_WORDS - 1) mInFrame = 0;
        else mWord++;
      end
    end
    if (done) begin
      if (!mValid || rd) begin
        mDout  = DATA_W'(acc >> PAR);
        mFirst = (wIdx == 0);
        mLast  = (wIdx == FRAME_WORDS - 1);
        mPerr  = (($countones(acc) % 2) == 1);
        mValid = 1;
      end else begin
        setOvr = 1;
      end
    end else if (mValid && rd) begin
      mValid = 0;
    end
    if (setOvr) mOvr = 1;
    else if (cl) mOvr = 0;
  endtask

  task automatic compareAll();
    checkOutput("dout_valid", bus.dout_valid, mValid);
    checkOutput("dout", bus.dout, mDout);
    checkOutput("frame_first", bus.frame_first, mFirst);
    checkOutput("frame_last", bus.frame_last, mLast);
    checkOutput("overrun", overrun, mOvr);
`ifdef BIT_FRAME_PARITY_EN
    checkOutput("parity_err", bus.parity_err, mPerr);
`endif
  endtask

  // One clock cycle: drive at negedge, record handshake, step model, compare after edge
  task automatic applyStimulus(input logic d, input logic lk, input logic rd, input logic cl, input logic rs);
    @(negedge clk);
    din = d; lock = lk; bus.dout_ready = rd; ovrClr = cl; rst = rs;
    #1;
    if (!rs && bus.dout_valid && rd) delivered.push_back(bus.dout);
    @(posedge clk);
    modelStep(d, lk, rd, cl, rs);
    #1;
    compareAll();
  endtask

  function automatic logic readyFor(input int idx);
    case (readyMode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return 1'($urandom_range(0, 1));
      default: return (idx == readyAt);
    endcase
  endfunction

  task automatic idle(input int n, input logic rd);
    for (int i = 0; i < n; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0, rd, 1'b0, 1'b0);
  endtask

  // Lock pulse on the first payload bit, then the frame back-to-back; abortAt>=0 resets at that bit
  task automatic sendFrame(input logic [DATA_W-1:0] words[FRAME_WORDS], input int abortAt);
    int idx;
    idx = 0;
    for (int w = 0; w < FRAME_WORDS; w++) begin
      for (int b = 0; b < WB; b++) begin
        logic bv, lk, rd, cl;
        if (b < DATA_W) bv = words[w][DATA_W-1-b];
        else bv = (^words[w]) ^ 1'(parFlip);
        lk = (idx == 0) ? 1'b1 : (lockNoise != 0 ? 1'($urandom_range(0, 1)) : 1'b0);
        rd = readyFor(idx);
        cl = ($urandom_range(0, 99) < clrPct) ? 1'b1 : 1'b0;
        if (idx == abortAt) begin
          applyStimulus(bv, lk, rd, 1'b0, 1'b1);
          return;
        end
        applyStimulus(bv, lk, rd, cl, 1'b0);
        idx++;
      end
    end
  endtask

  task automatic checkDelivered(input string tag);
    checkOutput({tag, "_count"}, delivered.size(), expWords.size());
    for (int i = 0; i < expWords.size() && i < delivered.size(); i++)
      checkOutput(tag, delivered[i], expWords[i]);
  endtask

  initial begin
    logic [DATA_W-1:0] fr[FRAME_WORDS];
    logic [DATA_W-1:0] fr2[FRAME_WORDS];
    bus.dout_ready = 1'b0;

    // T1: reset with din toggling and lock high
    $display("[TB] T1 reset");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_valid", bus.dout_valid, 0);
    checkOutput("t1_dout", bus.dout, 0);
    checkOutput("t1_overrun", overrun, 0);
    idle(3, 1'b1);
    checkOutput("t1_idle_valid", bus.dout_valid, 0);

    // T2: basic frame, consumer always ready
    $display("[TB] T2 basic frame");
    fr = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    delivered.delete();
    expWords = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    readyMode = 0;
    sendFrame(fr, -1);
    idle(2, 1'b1);
    checkDelivered("t2_word");

    // T3: backpressure for the whole frame, then clear overrun
    $display("[TB] T3 backpressure");
    readyMode = 1;
    sendFrame(fr, -1);
    checkOutput("t3_dout", bus.dout, 8'hA5);
    checkOutput("t3_valid", bus.dout_valid, 1);
    checkOutput("t3_overrun", overrun, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t3_ovr_clr", overrun, 0);
    idle(2, 1'b1);

    // T4: ready only at the completion edge of word 1
    $display("[TB] T4 simultaneous accept and load");
    readyMode = 3;
    readyAt = 2 * WB - 1;
    sendFrame(fr, -1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // T5: lock noise inside payload, then a back-to-back frame
    $display("[TB] T5 lock in payload");
    readyMode = 0;
    lockNoise = 1;
    fr  = '{8'h99, 8'h12, 8'h99, 8'hC3};
    fr2 = '{8'h5A, 8'h99, 8'h01, 8'h80};
    delivered.delete();
    expWords = '{8'h99, 8'h12, 8'h99, 8'hC3, 8'h5A, 8'h99, 8'h01, 8'h80};
    sendFrame(fr, -1);
    sendFrame(fr2, -1);
    idle(2, 1'b1);
    checkDelivered("t5_word");
    lockNoise = 0;

    // T6: reset at bit 3 of word 2, then a clean frame
    $display("[TB] T6 reset mid-word");
    fr = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    sendFrame(fr, 2 * WB + 3);
    checkOutput("t6_valid", bus.dout_valid, 0);
    idle(2, 1'b1);
    delivered.delete();
    expWords = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
`ifdef BIT_FRAME_PARITY_EN
    parFlip = 1;
`endif
    sendFrame(fr, -1);
    idle(2, 1'b1);
    checkDelivered("t6_word");
    parFlip = 0;

    // Randomized frames with random ready, lock noise, clears, gaps and aborts
    $display("[TB] random frames");
    for (int n = 0; n < 60; n++) begin
      for (int w = 0; w < FRAME_WORDS; w++) fr[w] = DATA_W'($urandom);
      readyMode = 2;
      lockNoise = $urandom_range(0, 1);
      clrPct    = $urandom_range(0, 20);
      parFlip   = (PAR != 0) ? $urandom_range(0, 1) : 0;
      sendFrame(fr, ($urandom_range(0, 9) == 0) ? $urandom_range(0, FRAME_WORDS * WB - 1) : -1);
      idle($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    idle(3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
